toast_mem_port_arbiter: RTL and testbench

//  Shares one pipelined single-port memory between instruction fetch (IF) and
//  the load/store unit (DM) of the RV32I core. Data port has priority. Branch

---
 rtl/toast_mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_toast_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toast_mem_port_arbiter.sv
// toast_mem_port_arbiter
// Shares one pipelined single-port memory between instruction fetch (IF) and
// the load/store unit (DM). DM has priority over IF. A branch flush kills any
// fetch still in flight. Read responses go back to the requester that issued
// them, in issue order, READ_LATENCY+1 cycles after the request is accepted.
//
// Optional feature: define TOAST_ARB_STARVE_GUARD_EN to enable the IF
// starvation guard. After MAX_STARVE consecutive DM grants with IF waiting,
// IF is forced through for one cycle. Without the macro, DM has strict
// priority and IF can wait indefinitely.
module toast_mem_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_STARVE   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        dm_req_valid,
  input  logic [31:0] dm_req_addr,
  input  logic        dm_req_wr_en,
  input  logic [31:0] dm_req_wr_data,
  input  logic [3:0]  dm_req_byte_en,
  output logic        dm_req_ready,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rd_data
);

  // Elaboration guard: the tag pipeline is only sized for latencies 1..4.
  if (READ_LATENCY < 1 || READ_LATENCY > 4 || MAX_STARVE < 1) begin : g_bad_params
    $error("toast_mem_port_arbiter: READ_LATENCY must be 1..4 and MAX_STARVE >= 1");
  end

  // One tag per accepted access, travelling alongside it through the memory.
  typedef struct packed {
    logic valid;
    logic owner_dm;
    logic is_store;
  } tag_t;

  tag_t [READ_LATENCY:0] tag_pipe;
  tag_t                  head;
  logic                  force_if;

`ifdef TOAST_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(MAX_STARVE + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign force_if = (starve_cnt == STARVE_W'(MAX_STARVE));

  // Count DM grants that IF has been waiting behind; any IF grant or IF going idle restarts the count.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (if_req_ready || !if_req_valid) begin
      starve_cnt <= '0;
    end else if (dm_req_ready && !if_flush) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Single-grant arbitration: DM first unless IF is being forced; nothing is granted while in reset.
  always_comb begin
    dm_req_ready = !Reset && dm_req_valid && !force_if;
    if_req_ready = !Reset && if_req_valid && !dm_req_ready && !if_flush;
  end

  // Register the granted request onto the memory port; idle cycles only drop mem_req.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      mem_byte_en <= '0;
    end else begin
      mem_req <= dm_req_ready || if_req_ready;
      if (dm_req_ready) begin
        mem_addr  <= dm_req_addr;
        mem_wr_en <= dm_req_wr_en;
        if (dm_req_wr_en) begin
          mem_wr_data <= dm_req_wr_data;
          mem_byte_en <= dm_req_byte_en;
        end else begin
          mem_byte_en <= 4'hF;
        end
      end else if (if_req_ready) begin
        mem_addr    <= if_req_addr;
        mem_wr_en   <= 1'b0;
        mem_byte_en <= 4'hF;
      end
    end
  end

  // Shift the tag pipeline every cycle; a flush invalidates every IF tag as it moves along.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0].valid    <= dm_req_ready || if_req_ready;
      tag_pipe[0].owner_dm <= dm_req_ready;
      tag_pipe[0].is_store <= dm_req_ready && dm_req_wr_en;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tag_pipe[i].valid    <= tag_pipe[i-1].valid && !(if_flush && !tag_pipe[i-1].owner_dm);
        tag_pipe[i].owner_dm <= tag_pipe[i-1].owner_dm;
        tag_pipe[i].is_store <= tag_pipe[i-1].is_store;
      end
    end
  end

  assign head = tag_pipe[READ_LATENCY];

  // Steer the returning memory data to its owner; a fetch arriving in a flush cycle is also dropped.
  always_comb begin
    if_rsp_valid = !Reset && head.valid && !head.owner_dm && !if_flush;
    dm_rsp_valid = !Reset && head.valid && head.owner_dm;
    if_rsp_data  = if_rsp_valid ? mem_rd_data : 32'h0;
    dm_rsp_data  = (dm_rsp_valid && !head.is_store) ? mem_rd_data : 32'h0;
  end

endmodule

// File: tb/tb_toast_mem_port_arbiter.sv
// Testbench for toast_mem_port_arbiter.
// Directed scenarios followed by a randomized run, all checked each cycle
// against a transaction-level model: every grant becomes an expected response
// due READ_LATENCY+1 cycles later, killed if a flush arrives before delivery.
// Define TOAST_ARB_STARVE_GUARD_EN for both bench and RTL to check the guard.
module tb_toast_mem_port_arbiter;

  localparam int LAT  = 1;
  localparam int MAXS = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid;
  logic [31:0] dm_req_addr;
  logic        dm_req_wr_en;
  logic [31:0] dm_req_wr_data;
  logic [3:0]  dm_req_byte_en;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rd_data;

  always #5 Clk = ~Clk;

  toast_mem_port_arbiter #(.READ_LATENCY(LAT), .MAX_STARVE(MAXS)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_flush       (if_flush),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .dm_req_valid   (dm_req_valid),
    .dm_req_addr    (dm_req_addr),
    .dm_req_wr_en   (dm_req_wr_en),
    .dm_req_wr_data (dm_req_wr_data),
    .dm_req_byte_en (dm_req_byte_en),
    .dm_req_ready   (dm_req_ready),
    .dm_rsp_valid   (dm_rsp_valid),
    .dm_rsp_data    (dm_rsp_data),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_data    (mem_wr_data),
    .mem_byte_en    (mem_byte_en),
    .mem_rd_data    (mem_rd_data)
  );

  typedef struct {
    int          due;
    bit          is_if;
    bit          is_store;
    logic [31:0] data;
    bit          killed;
  } exp_t;

  exp_t        pend[$];
  int          cyc;
  int          n_pass;
  int          n_fail;
  int          n_total;
  int          starve;
  bit          mem_known;
  logic        exp_mem_req;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_wen;
  logic [3:0]  exp_be;
  logic        hist_req  [LAT];
  logic        hist_wen  [LAT];
  logic [31:0] hist_addr [LAT];
  int          if_grants;
  int          dm_grants;
  int          if_rsps;
  int          dm_rsps;
  logic [31:0] last_if_data;
  logic [31:0] last_dm_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Run one clock cycle: compare the DUT against the model, then advance the model.
  task automatic checkOutput();
    bit          force_if;
    bit          g_dm;
    bit          g_if;
    bit          e_ifv;
    bit          e_dmv;
    logic [31:0] e_ifd;
    logic [31:0] e_dmd;
    force_if = 1'b0;
    e_ifv = 1'b0;
    e_dmv = 1'b0;
    e_ifd = 32'h0;
    e_dmd = 32'h0;
    @(negedge Clk);
`ifdef TOAST_ARB_STARVE_GUARD_EN
    force_if = (starve == MAXS);
`endif
    g_dm = !Reset && dm_req_valid && !force_if;
    g_if = !Reset && if_req_valid && !g_dm && !if_flush;
    if (!Reset) begin
      if (if_flush) begin
        foreach (pend[i]) if (pend[i].is_if) pend[i].killed = 1'b1;
      end
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          if (pend[i].is_if) begin
            e_ifv = !pend[i].killed;
            e_ifd = pend[i].data;
          end else begin
            e_dmv = 1'b1;
            e_dmd = pend[i].is_store ? 32'h0 : pend[i].data;
          end
        end
      end
    end
    check("dm_req_ready", 32'(dm_req_ready), 32'(g_dm));
    check("if_req_ready", 32'(if_req_ready), 32'(g_if));
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
    check("dm_rsp_valid", 32'(dm_rsp_valid), 32'(e_dmv));
    if (e_ifv) check("if_rsp_data", if_rsp_data, e_ifd);
    if (e_dmv) check("dm_rsp_data", dm_rsp_data, e_dmd);
    if (mem_known) begin
      check("mem_req", 32'(mem_req), 32'(exp_mem_req));
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wr_en", 32'(mem_wr_en), 32'(exp_wen));
      check("mem_byte_en", 32'(mem_byte_en), 32'(exp_be));
      if (exp_wen) check("mem_wr_data", mem_wr_data, exp_wdata);
    end
    if (if_req_ready) if_grants++;
    if (dm_req_ready) dm_grants++;
    if (if_rsp_valid) begin
      if_rsps++;
      last_if_data = if_rsp_data;
    end
    if (dm_rsp_valid) begin
      dm_rsps++;
      last_dm_data = dm_rsp_data;
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    if (Reset) begin
      pend.delete();
      exp_mem_req = 1'b0;
      exp_addr    = 32'h0;
      exp_wdata   = 32'h0;
      exp_wen     = 1'b0;
      exp_be      = 4'h0;
      starve      = 0;
      mem_known   = 1'b1;
    end else begin
      exp_mem_req = g_dm || g_if;
      if (g_dm) begin
        pend.push_back('{cyc + LAT + 1, 1'b0, dm_req_wr_en, dm_req_addr + 32'h100, 1'b0});
        exp_addr = dm_req_addr;
        exp_wen  = dm_req_wr_en;
        if (dm_req_wr_en) begin
          exp_wdata = dm_req_wr_data;
          exp_be    = dm_req_byte_en;
        end else begin
          exp_be = 4'hF;
        end
      end else if (g_if) begin
        pend.push_back('{cyc + LAT + 1, 1'b1, 1'b0, if_req_addr + 32'h100, 1'b0});
        exp_addr = if_req_addr;
        exp_wen  = 1'b0;
        exp_be   = 4'hF;
      end
      if (!if_req_valid || g_if) starve = 0;
      else if (g_dm && !if_flush) starve++;
    end
    for (int i = LAT - 1; i > 0; i--) begin
      hist_req[i]  = hist_req[i-1];
      hist_wen[i]  = hist_wen[i-1];
      hist_addr[i] = hist_addr[i-1];
    end
    hist_req[0]  = mem_req;
    hist_wen[0]  = mem_wr_en;
    hist_addr[0] = mem_addr;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Drive one cycle of requester inputs plus the memory's read data, then check that cycle.
  task automatic applyStimulus(input bit rst, input bit ifv, input logic [31:0] ifa, input bit fl,
                               input bit dmv, input logic [31:0] dma, input bit dmw,
                               input logic [31:0] dmd, input logic [3:0] dmbe);
    Reset          = rst;
    if_req_valid   = ifv;
    if_req_addr    = ifa;
    if_flush       = fl;
    dm_req_valid   = dmv;
    dm_req_addr    = dma;
    dm_req_wr_en   = dmw;
    dm_req_wr_data = dmd;
    dm_req_byte_en = dmbe;
    if (hist_req[LAT-1] === 1'b1 && hist_wen[LAT-1] === 1'b0)
      mem_rd_data = hist_addr[LAT-1] + 32'h100;
    else
      mem_rd_data = $urandom;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
  endtask

  initial begin
    int g0;
    int r0;
    cyc = 0; n_pass = 0; n_fail = 0; n_total = 0; starve = 0; mem_known = 1'b0;
    if_grants = 0; dm_grants = 0; if_rsps = 0; dm_rsps = 0;
    last_if_data = 32'h0; last_dm_data = 32'h0;
    exp_mem_req = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_wen = 1'b0; exp_be = 4'h0;
    for (int i = 0; i < LAT; i++) begin
      hist_req[i] = 1'b0; hist_wen[i] = 1'b0; hist_addr[i] = 32'h0;
    end
    #1;

    $display("[TB] reset with both requesters valid");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'h40, 0, 1, 32'h80, 0, 32'h0, 4'h0);
    g0 = dm_grants;
    applyStimulus(0, 1, 32'h40, 0, 1, 32'h80, 0, 32'h0, 4'h0);
    check("dm_first_after_reset", 32'(dm_grants - g0), 32'd1);
    idle(4);

    $display("[TB] back-to-back fetches");
    r0 = if_rsps;
    applyStimulus(0, 1, 32'h0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    applyStimulus(0, 1, 32'h4, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    applyStimulus(0, 1, 32'h8, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    idle(4);
    check("fetch_rsp_count", 32'(if_rsps - r0), 32'd3);
    check("fetch_last_data", last_if_data, 32'h108);

    $display("[TB] DM priority over IF");
    g0 = if_grants;
    r0 = dm_rsps;
    applyStimulus(0, 1, 32'h50, 0, 1, 32'h200, 0, 32'h0, 4'h0);
    check("if_blocked_by_dm", 32'(if_grants - g0), 32'd0);
    applyStimulus(0, 1, 32'h50, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    check("if_granted_next", 32'(if_grants - g0), 32'd1);
    idle(4);
    check("dm_load_rsp", 32'(dm_rsps - r0), 32'd1);
    check("dm_load_data", last_dm_data, 32'h300);

    $display("[TB] flush kills in-flight fetch");
    r0 = if_rsps;
    applyStimulus(0, 1, 32'h14, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 4'h0);
    applyStimulus(0, 1, 32'h24, 0, 0, 32'h0, 0, 32'h0, 4'h0);
    idle(4);
    check("flush_rsp_count", 32'(if_rsps - r0), 32'd1);
    check("flush_next_data", last_if_data, 32'h124);

    $display("[TB] store");
    r0 = dm_rsps;
    last_dm_data = 32'hFFFF_FFFF;
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h300, 1, 32'hDEADBEEF, 4'b0011);
    idle(4);
    check("store_ack", 32'(dm_rsps - r0), 32'd1);
    check("store_ack_data", last_dm_data, 32'h0);

    $display("[TB] sustained contention");
    g0 = if_grants;
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 32'h60, 0, 1, 32'h400 + 32'(i * 4), 0, 32'h0, 4'h0);
`ifdef TOAST_ARB_STARVE_GUARD_EN
    check("starve_if_grants", 32'(if_grants - g0), 32'd3);
`else
    check("starve_if_grants", 32'(if_grants - g0), 32'd0);
`endif
    idle(4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99) == 0,
                    $urandom_range(99) < 70, {$urandom_range(16'hFFFF), 2'b00}, $urandom_range(99) < 10,
                    $urandom_range(99) < 45, {$urandom_range(16'hFFFF), 2'b00}, $urandom_range(1) == 1,
                    $urandom, 4'($urandom_range(15)));
    end
    idle(LAT + 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
